// File: rtl/testdrive_axi4_lite_master_engine.sv
// AXI4-Lite master: converts a command/response stream into single-outstanding
// AXI4-Lite reads and writes, reporting response code, read data and latency.
module testdrive_axi4_lite_master_engine #(
    parameter int unsigned C_ADDR_WIDTH = 20,
    parameter int unsigned C_LAT_WIDTH  = 16
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    CMD_VALID,
    output logic                    CMD_READY,
    input  logic                    CMD_WRITE,
    input  logic [C_ADDR_WIDTH-1:0] CMD_ADDR,
    input  logic [31:0]             CMD_WDATA,
    input  logic [3:0]              CMD_WSTRB,
    output logic                    RSP_VALID,
    input  logic                    RSP_READY,
    output logic                    RSP_WRITE,
    output logic [1:0]              RSP_RESP,
    output logic [31:0]             RSP_RDATA,
    output logic [C_LAT_WIDTH-1:0]  RSP_LATENCY,
    output logic [C_ADDR_WIDTH-1:0] AWADDR,
    output logic                    AWVALID,
    input  logic                    AWREADY,
    output logic [31:0]             WDATA,
    output logic [3:0]              WSTRB,
    output logic                    WVALID,
    input  logic                    WREADY,
    input  logic [1:0]              BRESP,
    input  logic                    BVALID,
    output logic                    BREADY,
    output logic [C_ADDR_WIDTH-1:0] ARADDR,
    output logic                    ARVALID,
    input  logic                    ARREADY,
    input  logic [31:0]             RDATA,
    input  logic [1:0]              RRESP,
    input  logic                    RVALID,
    output logic                    RREADY
);

    typedef enum logic [2:0] {
        IDLE,
        WADDR_DATA,
        WRESP,
        RADDR,
        RDATA_WAIT,
        RESP
    } state_t;

    localparam logic [C_LAT_WIDTH-1:0] LAT_ONE = 1;

    state_t                  state_q;
    logic                    cmd_ready_q;
    logic                    awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;
    logic [C_ADDR_WIDTH-1:0] awaddr_q, araddr_q;
    logic [31:0]             wdata_q;
    logic [3:0]              wstrb_q;
    logic                    rsp_valid_q, rsp_write_q;
    logic [1:0]              rsp_resp_q;
    logic [31:0]             rsp_rdata_q;
    logic [C_LAT_WIDTH-1:0]  rsp_latency_q;
    logic [C_LAT_WIDTH-1:0]  lat_q, lat_d;
    logic                    aw_done_d, w_done_d;

    always_comb begin
        lat_d     = (&lat_q) ? lat_q : lat_q + LAT_ONE;
        aw_done_d = !awvalid_q || AWREADY;
        w_done_d  = !wvalid_q || WREADY;
    end

    // The idle-ready flag resets high but is masked while reset is held.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q       <= IDLE;
            cmd_ready_q   <= 1'b1;
            awvalid_q     <= 1'b0;
            wvalid_q      <= 1'b0;
            bready_q      <= 1'b0;
            arvalid_q     <= 1'b0;
            rready_q      <= 1'b0;
            awaddr_q      <= '0;
            araddr_q      <= '0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_write_q   <= 1'b0;
            rsp_resp_q    <= '0;
            rsp_rdata_q   <= '0;
            rsp_latency_q <= '0;
            lat_q         <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (CMD_VALID) begin
                        cmd_ready_q <= 1'b0;
                        lat_q       <= LAT_ONE;
                        if (CMD_WRITE) begin
                            awaddr_q  <= CMD_ADDR;
                            wdata_q   <= CMD_WDATA;
                            wstrb_q   <= CMD_WSTRB;
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            state_q   <= WADDR_DATA;
                        end else begin
                            araddr_q  <= CMD_ADDR;
                            arvalid_q <= 1'b1;
                            state_q   <= RADDR;
                        end
                    end
                end
                WADDR_DATA: begin
                    lat_q <= lat_d;
                    if (AWREADY) awvalid_q <= 1'b0;
                    if (WREADY)  wvalid_q  <= 1'b0;
                    if (aw_done_d && w_done_d) begin
                        bready_q <= 1'b1;
                        state_q  <= WRESP;
                    end
                end
                WRESP: begin
                    lat_q <= lat_d;
                    if (BVALID) begin
                        bready_q      <= 1'b0;
                        rsp_valid_q   <= 1'b1;
                        rsp_write_q   <= 1'b1;
                        rsp_resp_q    <= BRESP;
                        rsp_rdata_q   <= '0;
                        rsp_latency_q <= lat_d;
                        state_q       <= RESP;
                    end
                end
                RADDR: begin
                    lat_q <= lat_d;
                    if (ARREADY) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= RDATA_WAIT;
                    end
                end
                RDATA_WAIT: begin
                    lat_q <= lat_d;
                    if (RVALID) begin
                        rready_q      <= 1'b0;
                        rsp_valid_q   <= 1'b1;
                        rsp_write_q   <= 1'b0;
                        rsp_resp_q    <= RRESP;
                        rsp_rdata_q   <= RDATA;
                        rsp_latency_q <= lat_d;
                        state_q       <= RESP;
                    end
                end
                RESP: begin
                    if (RSP_READY) begin
                        rsp_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign CMD_READY   = cmd_ready_q && !RST;
    assign AWVALID     = awvalid_q;
    assign AWADDR      = awaddr_q;
    assign WVALID      = wvalid_q;
    assign WDATA       = wdata_q;
    assign WSTRB       = wstrb_q;
    assign BREADY      = bready_q;
    assign ARVALID     = arvalid_q;
    assign ARADDR      = araddr_q;
    assign RREADY      = rready_q;
    assign RSP_VALID   = rsp_valid_q;
    assign RSP_WRITE   = rsp_write_q;
    assign RSP_RESP    = rsp_resp_q;
    assign RSP_RDATA   = rsp_rdata_q;
    assign RSP_LATENCY = rsp_latency_q;

endmodule

// File: tb/tb_testdrive_axi4_lite_master_engine.sv
// Scoreboard bench for the AXI4-Lite master engine: scripted slave responses,
// expected responses queued at command issue and popped on RSP_VALID.
module tb_testdrive_axi4_lite_master_engine;

    localparam int unsigned AW = 20;
    localparam int unsigned LW = 16;

    typedef struct {
        bit          wr;
        logic [1:0]  resp;
        logic [31:0] rdata;
        logic [15:0] lat;
    } exp_t;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          CMD_VALID = 1'b0, CMD_READY, CMD_WRITE = 1'b0;
    logic [AW-1:0] CMD_ADDR = '0;
    logic [31:0]   CMD_WDATA = '0;
    logic [3:0]    CMD_WSTRB = '0;
    logic          RSP_VALID, RSP_READY = 1'b0, RSP_WRITE;
    logic [1:0]    RSP_RESP;
    logic [31:0]   RSP_RDATA;
    logic [LW-1:0] RSP_LATENCY;
    logic [AW-1:0] AWADDR, ARADDR;
    logic          AWVALID, AWREADY = 1'b0;
    logic [31:0]   WDATA;
    logic [3:0]    WSTRB;
    logic          WVALID, WREADY = 1'b0;
    logic [1:0]    BRESP = '0;
    logic          BVALID = 1'b0, BREADY;
    logic          ARVALID, ARREADY = 1'b0;
    logic [31:0]   RDATA = '0;
    logic [1:0]    RRESP = '0;
    logic          RVALID = 1'b0, RREADY;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    exp_t        sb[$];
    exp_t        e;
    bit          ok;

    always #5 CLK = ~CLK;

    testdrive_axi4_lite_master_engine #(
        .C_ADDR_WIDTH(AW),
        .C_LAT_WIDTH (LW)
    ) dut (
        .CLK(CLK), .RST(RST),
        .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_WRITE(CMD_WRITE),
        .CMD_ADDR(CMD_ADDR), .CMD_WDATA(CMD_WDATA), .CMD_WSTRB(CMD_WSTRB),
        .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_WRITE(RSP_WRITE),
        .RSP_RESP(RSP_RESP), .RSP_RDATA(RSP_RDATA), .RSP_LATENCY(RSP_LATENCY),
        .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic issue(input bit wr, input logic [AW-1:0] addr,
                         input logic [31:0] data, input logic [3:0] strb);
        CMD_VALID = 1'b1;
        CMD_WRITE = wr;
        CMD_ADDR  = addr;
        CMD_WDATA = data;
        CMD_WSTRB = strb;
        tick();
        CMD_VALID = 1'b0;
    endtask

    task automatic wait_rsp(input int unsigned budget, output bit found);
        found = 1'b0;
        for (int unsigned i = 0; i < budget; i++) begin
            if (RSP_VALID === 1'b1) begin
                found = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic release_rsp();
        RSP_READY = 1'b1;
        tick();
        RSP_READY = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        n_checks++;
        if ({CMD_READY, AWVALID, WVALID, BREADY, ARVALID, RREADY, RSP_VALID} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_valids: got %b required 0000000",
                     {CMD_READY, AWVALID, WVALID, BREADY, ARVALID, RREADY, RSP_VALID});
        end
        n_checks++;
        if ({AWADDR, WDATA, WSTRB, ARADDR, RSP_WRITE, RSP_RESP, RSP_RDATA, RSP_LATENCY} !== '0) begin
            n_fail++;
            $display("FAIL reset_data: got awaddr=%h wdata=%h araddr=%h rdata=%h lat=%0d required all 0",
                     AWADDR, WDATA, ARADDR, RSP_RDATA, RSP_LATENCY);
        end
        @(negedge CLK);
        RST = 1'b0;
        #1;
        n_checks++;
        if (CMD_READY !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_ready: got %b required 1", CMD_READY);
        end
        tick();
    endtask

    task automatic test_write_zero_wait();
        AWREADY = 1'b1;
        WREADY  = 1'b1;
        issue(1'b1, 20'h00010, 32'hDEADBEEF, 4'hF);
        sb.push_back('{wr: 1'b1, resp: 2'b00, rdata: 32'h0, lat: 16'd3});
        n_checks++;
        if ({AWVALID, WVALID, AWADDR, WDATA, WSTRB} !== {2'b11, 20'h00010, 32'hDEADBEEF, 4'hF}) begin
            n_fail++;
            $display("FAIL wz_aw_w: got aw=%b w=%b addr=%h data=%h strb=%h required 1 1 00010 deadbeef f",
                     AWVALID, WVALID, AWADDR, WDATA, WSTRB);
        end
        tick();
        AWREADY = 1'b0;
        WREADY  = 1'b0;
        n_checks++;
        if ({AWVALID, WVALID, BREADY} !== 3'b001) begin
            n_fail++;
            $display("FAIL wz_one_cycle: got aw/w/bready=%b required 001", {AWVALID, WVALID, BREADY});
        end
        BVALID = 1'b1;
        BRESP  = 2'b00;
        tick();
        BVALID = 1'b0;
        wait_rsp(20, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL wz_rsp_timeout: RSP_VALID=%b required 1", RSP_VALID);
        end else begin
            e = sb.pop_front();
            n_checks++;
            if ({RSP_WRITE, RSP_RESP, RSP_RDATA, RSP_LATENCY} !== {e.wr, e.resp, e.rdata, e.lat}) begin
                n_fail++;
                $display("FAIL wz_rsp: got w=%b resp=%b rdata=%h lat=%0d required w=%b resp=%b rdata=%h lat=%0d",
                         RSP_WRITE, RSP_RESP, RSP_RDATA, RSP_LATENCY, e.wr, e.resp, e.rdata, e.lat);
            end
        end
        release_rsp();
        n_checks++;
        if ({RSP_VALID, CMD_READY} !== 2'b01) begin
            n_fail++;
            $display("FAIL wz_back_to_idle: got rsp_valid/cmd_ready=%b required 01", {RSP_VALID, CMD_READY});
        end
    endtask

    task automatic test_read_delayed();
        issue(1'b0, 20'h00020, 32'h0, 4'h0);
        sb.push_back('{wr: 1'b0, resp: 2'b00, rdata: 32'h12345678, lat: 16'd8});
        for (int unsigned i = 0; i < 5; i++) begin
            if (i == 4) ARREADY = 1'b1;
            n_checks++;
            if ({ARVALID, ARADDR} !== {1'b1, 20'h00020}) begin
                n_fail++;
                $display("FAIL rd_arvalid_hold[%0d]: got arvalid=%b araddr=%h required 1 00020", i, ARVALID, ARADDR);
            end
            tick();
        end
        ARREADY = 1'b0;
        n_checks++;
        if ({ARVALID, RREADY} !== 2'b01) begin
            n_fail++;
            $display("FAIL rd_ar_done: got arvalid/rready=%b required 01", {ARVALID, RREADY});
        end
        tick();
        RVALID = 1'b1;
        RDATA  = 32'h12345678;
        RRESP  = 2'b00;
        tick();
        RVALID = 1'b0;
        wait_rsp(20, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL rd_rsp_timeout: RSP_VALID=%b required 1", RSP_VALID);
        end else begin
            e = sb.pop_front();
            n_checks++;
            if ({RSP_WRITE, RSP_RESP, RSP_RDATA, RSP_LATENCY} !== {e.wr, e.resp, e.rdata, e.lat}) begin
                n_fail++;
                $display("FAIL rd_rsp: got w=%b resp=%b rdata=%h lat=%0d required w=%b resp=%b rdata=%h lat=%0d",
                         RSP_WRITE, RSP_RESP, RSP_RDATA, RSP_LATENCY, e.wr, e.resp, e.rdata, e.lat);
            end
        end
        release_rsp();
    endtask

    task automatic test_write_split();
        issue(1'b1, 20'h00030, 32'hA5A5_5A5A, 4'h3);
        sb.push_back('{wr: 1'b1, resp: 2'b01, rdata: 32'h0, lat: 16'd6});
        WREADY = 1'b1;
        tick();
        WREADY = 1'b0;
        for (int unsigned i = 0; i < 3; i++) begin
            if (i == 2) AWREADY = 1'b1;
            n_checks++;
            if ({AWVALID, WVALID, BREADY, AWADDR} !== {3'b100, 20'h00030}) begin
                n_fail++;
                $display("FAIL ws_aw_pending[%0d]: got aw/w/bready=%b awaddr=%h required 100 00030",
                         i, {AWVALID, WVALID, BREADY}, AWADDR);
            end
            tick();
        end
        AWREADY = 1'b0;
        n_checks++;
        if ({AWVALID, WVALID, BREADY} !== 3'b001) begin
            n_fail++;
            $display("FAIL ws_bready: got aw/w/bready=%b required 001", {AWVALID, WVALID, BREADY});
        end
        BVALID = 1'b1;
        BRESP  = 2'b01;
        tick();
        BVALID = 1'b0;
        wait_rsp(20, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL ws_rsp_timeout: RSP_VALID=%b required 1", RSP_VALID);
        end else begin
            e = sb.pop_front();
            n_checks++;
            if ({RSP_WRITE, RSP_RESP, RSP_RDATA, RSP_LATENCY} !== {e.wr, e.resp, e.rdata, e.lat}) begin
                n_fail++;
                $display("FAIL ws_rsp: got w=%b resp=%b rdata=%h lat=%0d required w=%b resp=%b rdata=%h lat=%0d",
                         RSP_WRITE, RSP_RESP, RSP_RDATA, RSP_LATENCY, e.wr, e.resp, e.rdata, e.lat);
            end
        end
        release_rsp();
        for (int unsigned i = 0; i < 3; i++) begin
            n_checks++;
            if ({RSP_VALID, BREADY, AWVALID} !== 3'b000) begin
                n_fail++;
                $display("FAIL ws_single_rsp[%0d]: got rsp_valid/bready/awvalid=%b required 000",
                         i, {RSP_VALID, BREADY, AWVALID});
            end
            tick();
        end
    endtask

    task automatic test_slverr_backpressure();
        ARREADY = 1'b1;
        issue(1'b0, 20'h00044, 32'h0, 4'h0);
        sb.push_back('{wr: 1'b0, resp: 2'b10, rdata: 32'hCAFEF00D, lat: 16'd3});
        tick();
        ARREADY = 1'b0;
        RVALID  = 1'b1;
        RRESP   = 2'b10;
        RDATA   = 32'hCAFEF00D;
        tick();
        RVALID = 1'b0;
        RDATA  = 32'h0;
        RRESP  = 2'b00;
        wait_rsp(20, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL se_rsp_timeout: RSP_VALID=%b required 1", RSP_VALID);
        end else begin
            e = sb.pop_front();
            for (int unsigned i = 0; i < 6; i++) begin
                n_checks++;
                if ({RSP_VALID, CMD_READY, RSP_WRITE, RSP_RESP, RSP_RDATA, RSP_LATENCY} !==
                    {2'b10, e.wr, e.resp, e.rdata, e.lat}) begin
                    n_fail++;
                    $display("FAIL se_hold[%0d]: got valid=%b cmd_ready=%b w=%b resp=%b rdata=%h lat=%0d required 1 0 %b %b %h %0d",
                             i, RSP_VALID, CMD_READY, RSP_WRITE, RSP_RESP, RSP_RDATA, RSP_LATENCY,
                             e.wr, e.resp, e.rdata, e.lat);
                end
                if (i == 5) RSP_READY = 1'b1;
                tick();
            end
            RSP_READY = 1'b0;
        end
        n_checks++;
        if ({RSP_VALID, CMD_READY} !== 2'b01) begin
            n_fail++;
            $display("FAIL se_back_to_idle: got rsp_valid/cmd_ready=%b required 01", {RSP_VALID, CMD_READY});
        end
    endtask

    task automatic test_latency_saturation();
        issue(1'b0, 20'h00050, 32'h0, 4'h0);
        sb.push_back('{wr: 1'b0, resp: 2'b00, rdata: 32'h0BADF00D, lat: 16'hFFFF});
        repeat (70000) tick();
        ARREADY = 1'b1;
        tick();
        ARREADY = 1'b0;
        RVALID  = 1'b1;
        RDATA   = 32'h0BADF00D;
        tick();
        RVALID = 1'b0;
        wait_rsp(20, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL sat_rsp_timeout: RSP_VALID=%b required 1", RSP_VALID);
        end else begin
            e = sb.pop_front();
            n_checks++;
            if ({RSP_WRITE, RSP_RESP, RSP_RDATA, RSP_LATENCY} !== {e.wr, e.resp, e.rdata, e.lat}) begin
                n_fail++;
                $display("FAIL sat_rsp: got w=%b resp=%b rdata=%h lat=%h required w=%b resp=%b rdata=%h lat=%h",
                         RSP_WRITE, RSP_RESP, RSP_RDATA, RSP_LATENCY, e.wr, e.resp, e.rdata, e.lat);
            end
        end
        release_rsp();
    endtask

    task automatic test_reset_mid_write();
        AWREADY = 1'b1;
        WREADY  = 1'b1;
        issue(1'b1, 20'h00060, 32'h11223344, 4'hF);
        tick();
        AWREADY = 1'b0;
        WREADY  = 1'b0;
        n_checks++;
        if (BREADY !== 1'b1) begin
            n_fail++;
            $display("FAIL rm_in_wresp: got BREADY=%b required 1", BREADY);
        end
        #2 RST = 1'b1;
        #1;
        n_checks++;
        if ({AWVALID, WVALID, BREADY, RSP_VALID, CMD_READY} !== 5'b0) begin
            n_fail++;
            $display("FAIL rm_async_drop: got aw/w/bready/rsp_valid/cmd_ready=%b required 00000",
                     {AWVALID, WVALID, BREADY, RSP_VALID, CMD_READY});
        end
        @(posedge CLK);
        #3 RST = 1'b0;
        tick();
        for (int unsigned i = 0; i < 3; i++) begin
            n_checks++;
            if ({CMD_READY, RSP_VALID, BREADY} !== 3'b100) begin
                n_fail++;
                $display("FAIL rm_after_release[%0d]: got cmd_ready/rsp_valid/bready=%b required 100",
                         i, {CMD_READY, RSP_VALID, BREADY});
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_write_zero_wait();
        test_read_delayed();
        test_write_split();
        test_slverr_backpressure();
        test_latency_saturation();
        test_reset_mid_write();
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
